// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid stage: occupancy states,
// the default payload width and a small occupancy helper.
package pipe_pkg;

  // Default payload: PC + rs1 + rs2, each 32 bits.
  localparam int PIPE_W = 96;

  // Occupancy of the stage: nothing held, main register only, main + skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  // Number of payloads held in a given occupancy state.
  function automatic logic [1:0] held_count(input skid_state_t state);
    case (state)
      BUSY:    held_count = 2'd1;
      FULL:    held_count = 2'd2;
      default: held_count = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// Pipeline register stage with a one-entry skid buffer. in_ready is a flop
// output, so the upstream ready path is cut from the downstream out_ready.
// A flush discards every held payload and counts the discarded ones in a
// saturating statistics counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [CNT_W-1:0] drop_cnt
);

  skid_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic             accept;
  logic             consume;
  logic [1:0]       drop_n;
  logic [CNT_W:0]   drop_sum;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign in_ready  = in_ready_q;
  assign drop_cnt  = drop_cnt_q;

  assign accept  = in_valid & in_ready_q;
  assign consume = out_valid & out_ready;

  // Payloads discarded by a flush: everything held minus the one consumed
  // in the same cycle; the extra top bit of the sum detects saturation.
  assign drop_n   = held_count(state_q) - {1'b0, consume};
  assign drop_sum = {1'b0, drop_cnt_q} + (CNT_W + 1)'(drop_n);

  // Next-state, datapath steering and statistics update.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    main_d     = main_q;
    skid_d     = skid_q;
    drop_cnt_d = drop_cnt_q;

    if (flush) begin
      // Flush wins over every handshake; the data registers keep their last
      // value so out_data stays stable while out_valid is low.
      state_d    = EMPTY;
      drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = BUSY;
            main_d  = in_data;
          end
        end
        BUSY: begin
          if (accept && consume) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the downstream side can move.
          if (consume) begin
            state_d = BUSY;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end

    // Ready for the next cycle is decided from the next occupancy only.
    in_ready_d = (state_d != FULL);
  end

  // State, data and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the data registers are reset as well because out_data must
      // read zero after reset, not merely be qualified by out_valid.
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      drop_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: a queue-based reference model
// compared every cycle, directed scenarios with literal expectations, and a
// random stream checked by an output scoreboard. A second instance with a
// 2-bit counter shares all stimulus to exercise counter saturation.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int W  = PIPE_W;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          out_ready = 1'b0;
  logic          flush = 1'b0;

  logic          in_ready, out_valid;
  logic [W-1:0]  out_data;
  logic [CW-1:0] drop_cnt;

  logic          in_ready2, out_valid2;
  logic [W-1:0]  out_data2;
  logic [1:0]    drop_cnt2;

  pipe_stage_skid #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .flush(flush), .drop_cnt(drop_cnt)
  );

  pipe_stage_skid #(.WIDTH(W), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready),
    .flush(flush), .drop_cnt(drop_cnt2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit compare_en = 1'b0;
  bit mon_en = 1'b0;
  int xfer_cnt = 0;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the stage is a FIFO of at most two payloads.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_last = '0;
  bit           m_in_ready = 1'b1;
  int           m_drop = 0;
  int           m_drop2 = 0;

  always @(posedge clk) begin : model
    bit acc, con;
    int n;
    acc = in_valid && m_in_ready;
    con = (mq.size() != 0) && out_ready;
    if (reset) begin
      mq.delete();
      m_last = '0;
      m_drop = 0;
      m_drop2 = 0;
      m_in_ready = 1'b1;
    end else if (flush) begin
      n = mq.size() - (con ? 1 : 0);
      m_drop  = (m_drop + n > 65535) ? 65535 : m_drop + n;
      m_drop2 = (m_drop2 + n > 3) ? 3 : m_drop2 + n;
      mq.delete();
      m_in_ready = 1'b1;
    end else begin
      if (con) void'(mq.pop_front());
      if (acc) mq.push_back(in_data);
      m_in_ready = (mq.size() < 2);
    end
    if (mq.size() != 0) m_last = mq[0];
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (compare_en) begin
      check("out_valid", W'(out_valid), W'(mq.size() != 0));
      check("out_data", out_data, m_last);
      check("in_ready", W'(in_ready), W'(m_in_ready));
      check("drop_cnt", W'(drop_cnt), W'(m_drop));
      check("sat out_valid", W'(out_valid2), W'(mq.size() != 0));
      check("sat out_data", out_data2, m_last);
      check("sat in_ready", W'(in_ready2), W'(m_in_ready));
      check("sat drop_cnt", W'(drop_cnt2), W'(m_drop2));
    end
  end

  // Output scoreboard for the random stream: transfers must match the
  // accepted payloads in order.
  logic [W-1:0] sb[$];
  always @(negedge clk) begin
    if (mon_en && !reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("stream unexpected output", W'(1), W'(0));
      end else begin
        check("stream order", out_data, sb.pop_front());
      end
      xfer_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From EMPTY, load two payloads with downstream stalled, ending in FULL.
  task automatic fill(input logic [W-1:0] a, input logic [W-1:0] b);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = a;
    step();
    in_data   = b;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin : stim
    int sent;
    int cyc;
    bit acc;
    int sat_exp[4];
    sat_exp = '{2, 3, 3, 3};

    // Reset state.
    reset = 1'b1;
    step();
    compare_en = 1'b1;
    step();
    reset = 1'b0;
    check("reset out_valid", W'(out_valid), W'(0));
    check("reset out_data", out_data, W'(0));
    check("reset in_ready", W'(in_ready), W'(1));
    check("reset drop_cnt", W'(drop_cnt), W'(0));

    // Single payload, latency one.
    in_valid = 1'b1; in_data = W'('hA); out_ready = 1'b1;
    step();
    check("lat1 out_valid", W'(out_valid), W'(1));
    check("lat1 out_data", out_data, W'('hA));
    check("lat1 drop_cnt", W'(drop_cnt), W'(0));
    in_valid = 1'b0;
    step();
    check("drain out_valid", W'(out_valid), W'(0));
    check("hold out_data", out_data, W'('hA));

    // Back-to-back with downstream stall, then release.
    out_ready = 1'b0; in_valid = 1'b1; in_data = W'('h1);
    step();
    in_data = W'('h2);
    step();
    check("full in_ready", W'(in_ready), W'(0));
    check("full out_data", out_data, W'('h1));
    in_data = W'('h3);
    step();
    check("stall in_ready", W'(in_ready), W'(0));
    check("stall out_data", out_data, W'('h1));
    out_ready = 1'b1;
    #1;
    check("in_ready ignores out_ready", W'(in_ready), W'(0));
    step();
    check("release out_data 2", out_data, W'('h2));
    check("release in_ready", W'(in_ready), W'(1));
    step();
    check("release out_data 3", out_data, W'('h3));
    in_valid = 1'b0;
    step();
    check("release empty", W'(out_valid), W'(0));

    // Flush of FULL without and with a same-cycle consume.
    fill(W'('hB), W'('hC));
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush2 out_valid", W'(out_valid), W'(0));
    check("flush2 drop_cnt", W'(drop_cnt), W'(2));
    check("flush2 in_ready", W'(in_ready), W'(1));
    do_reset();
    fill(W'('hB), W'('hC));
    out_ready = 1'b1;
    check("flush1 head", out_data, W'('hB));
    flush = 1'b1;
    step();
    flush = 1'b0;
    out_ready = 1'b0;
    check("flush1 drop_cnt", W'(drop_cnt), W'(1));
    check("flush1 out_valid", W'(out_valid), W'(0));

    // Saturation of the 2-bit counter over four flushes of FULL.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      fill(W'(16 + 2 * i), W'(17 + 2 * i));
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("sat drop_cnt2", W'(drop_cnt2), W'(sat_exp[i]));
    end
    check("sat drop_cnt16", W'(drop_cnt), W'(8));

    // Reset wins over flush while FULL.
    fill(W'('hD), W'('hE));
    reset = 1'b1; flush = 1'b1;
    step();
    reset = 1'b0; flush = 1'b0;
    check("rst+flush out_valid", W'(out_valid), W'(0));
    check("rst+flush out_data", out_data, W'(0));
    check("rst+flush drop_cnt", W'(drop_cnt), W'(0));
    check("rst+flush in_ready", W'(in_ready), W'(1));

    // Random stream of 100 payloads.
    mon_en = 1'b1;
    sent = 0;
    cyc = 0;
    in_valid = ($urandom_range(0, 3) != 0);
    in_data  = {$urandom(), $urandom(), $urandom()};
    while (sent < 100 && cyc < 3000) begin
      out_ready = $urandom_range(0, 1) == 1;
      acc = in_valid && in_ready;
      step();
      cyc++;
      if (acc) begin
        sb.push_back(in_data);
        sent++;
      end
      if (acc || !in_valid) begin
        in_valid = (sent < 100) && ($urandom_range(0, 3) != 0);
        in_data  = {$urandom(), $urandom(), $urandom()};
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("stream accepted", W'(sent), W'(100));
    check("stream transfers", W'(xfer_cnt), W'(100));
    check("stream leftover", W'(sb.size()), W'(0));
    mon_en = 1'b0;
    compare_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
